// File: rtl/morse_pkg.sv
// Shared Morse definitions: FSM encoding, letter indices and the pattern map
// used by both the blink encoder and this decoder.
package morse_pkg;

    typedef enum logic [1:0] {IDLE, MARK, SPACE, EMIT} state_t;

    localparam logic [2:0] L_S = 3'd0;
    localparam logic [2:0] L_T = 3'd1;
    localparam logic [2:0] L_U = 3'd2;
    localparam logic [2:0] L_V = 3'd3;
    localparam logic [2:0] L_W = 3'd4;
    localparam logic [2:0] L_X = 3'd5;
    localparam logic [2:0] L_Y = 3'd6;
    localparam logic [2:0] L_Z = 3'd7;

    // Symbol count value meaning "more than four symbols seen"
    localparam logic [2:0] LEN_OVF = 3'd5;

    // Patterns as {len, bits}; bits LSB = last symbol, 1 = dash, unused upper bits 0
    localparam logic [6:0] PAT_S = {3'd3, 4'b0000};
    localparam logic [6:0] PAT_T = {3'd1, 4'b0001};
    localparam logic [6:0] PAT_U = {3'd3, 4'b0001};
    localparam logic [6:0] PAT_V = {3'd4, 4'b0001};
    localparam logic [6:0] PAT_W = {3'd3, 4'b0011};
    localparam logic [6:0] PAT_X = {3'd4, 4'b1001};
    localparam logic [6:0] PAT_Y = {3'd4, 4'b1011};
    localparam logic [6:0] PAT_Z = {3'd4, 4'b1100};

    // Entry i holds the pattern of letter index i
    localparam logic [7:0][6:0] PAT_TABLE =
        {PAT_Z, PAT_Y, PAT_X, PAT_W, PAT_V, PAT_U, PAT_T, PAT_S};

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } lookup_t;

    function automatic lookup_t pattern_lookup(input logic [2:0] len, input logic [3:0] bits);
        lookup_t r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (PAT_TABLE[i] == {len, bits}) begin
                r.hit = 1'b1;
                r.idx = 3'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/morse_decoder_if.sv
// Key line in, decoded letter and symbol status out.
interface morse_decoder_if;
    logic       key_in;
    logic [2:0] letter;
    logic       letter_valid;
    logic       error;
    logic [3:0] sym_bits;
    logic [2:0] sym_len;
    logic       busy;

    modport master (output key_in,
                    input  letter, letter_valid, error, sym_bits, sym_len, busy);
    modport slave  (input  key_in,
                    output letter, letter_valid, error, sym_bits, sym_len, busy);
endinterface

// File: rtl/morse_run_counter.sv
// Synchronizes the key line, detects its edges and measures how long the
// line has held its current level.
module morse_run_counter
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 24999999,
    parameter int CW          = 26
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          key_in,
    output logic          rise,
    output logic          fall,
    output logic          at_thresh,
    output logic [CW-1:0] run_cnt
);
    localparam logic [CW-1:0] THRESH = CW'(2 * UNIT_CYCLES);

    logic sync1, key_s, key_d;

    // Two-flop synchronizer followed by a delay flop for edge detection
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b0;
            key_s <= 1'b0;
            key_d <= 1'b0;
        end else begin
            sync1 <= key_in;
            key_s <= sync1;
            key_d <= key_s;
        end
    end

    assign rise = key_s & ~key_d;
    assign fall = ~key_s & key_d;

    // Cycles since the last edge; saturating keeps long holds harmless
    always_ff @(posedge clock) begin
        if (reset)
            run_cnt <= '0;
        else if (rise || fall)
            run_cnt <= '0;
        else if (run_cnt != THRESH)
            run_cnt <= run_cnt + 1'b1;
    end

    // run_cnt lags the low level by two cycles (edge cycle + clear), so this
    // marks the cycle in which the space has lasted THRESH cycles
    assign at_thresh = ~key_s && (run_cnt == THRESH - CW'(2));

endmodule

// File: rtl/morse_decoder.sv
// Classifies marks as dot/dash, collects up to four symbols and emits the
// S..Z letter index (or an error) once a letter gap is seen.
module morse_decoder
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 24999999,
    parameter int CW          = 26
) (
    input logic            clock,
    input logic            reset,
    morse_decoder_if.slave bus
);
    localparam logic [CW-1:0] THRESH = CW'(2 * UNIT_CYCLES);

    logic          rise, fall, at_thresh, is_dash;
    logic [CW-1:0] run_cnt;
    state_t        state;
    logic [3:0]    sym_bits;
    logic [2:0]    sym_len, letter;
    logic          letter_valid, error;
    lookup_t       hit;

    morse_run_counter #(.UNIT_CYCLES(UNIT_CYCLES), .CW(CW)) u_run (
        .clock     (clock),
        .reset     (reset),
        .key_in    (bus.key_in),
        .rise      (rise),
        .fall      (fall),
        .at_thresh (at_thresh),
        .run_cnt   (run_cnt)
    );

    // On the fall cycle run_cnt = mark length - 1
    assign is_dash = run_cnt >= THRESH - CW'(1);
    assign hit     = pattern_lookup(sym_len, sym_bits);

    // Letter assembly FSM; pulses are registered and last one cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            sym_bits     <= '0;
            sym_len      <= '0;
            letter       <= '0;
            letter_valid <= 1'b0;
            error        <= 1'b0;
        end else begin
            letter_valid <= 1'b0;
            error        <= 1'b0;
            case (state)
                IDLE: if (rise) state <= MARK;
                MARK: begin
                    if (fall) begin
                        sym_bits <= {sym_bits[2:0], is_dash};
                        if (sym_len != LEN_OVF) sym_len <= sym_len + 3'd1;
                        state <= SPACE;
                    end
                end
                SPACE: begin
                    if (rise)           state <= MARK;
                    else if (at_thresh) state <= EMIT;
                end
                EMIT: begin
                    if (hit.hit) begin
                        letter       <= hit.idx;
                        letter_valid <= 1'b1;
                    end else begin
                        error <= 1'b1;
                    end
                    sym_bits <= '0;
                    sym_len  <= '0;
                    // A mark starting right at the gap end begins the next letter
                    state    <= rise ? MARK : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.letter       = letter;
    assign bus.letter_valid = letter_valid;
    assign bus.error        = error;
    assign bus.sym_bits     = sym_bits;
    assign bus.sym_len      = sym_len;
    assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_morse_decoder.sv
// Bench for morse_decoder: a string-level Morse model predicts every pulse,
// a per-cycle compare process checks it, and literal pins anchor the model.
module tb_morse_decoder;
    localparam int UNIT = 4;
    localparam int CW   = 5;
    localparam int TH   = 2 * UNIT;

    logic clock = 1'b0;
    logic reset = 1'b1;

    morse_decoder_if bus();

    morse_decoder #(.UNIT_CYCLES(UNIT), .CW(CW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        int cyc;
        bit err;
        int idx;
    } ev_t;

    ev_t   evq[$];
    int    cyc   = 0;
    bit    rst_q = 1'b1;
    int    n_cmp = 0;
    int    n_bad = 0;
    string cur   = "";
    int    mlen  = 0;
    int    last_drive = 0;
    int    last_n     = 1;
    string pats[8] = '{"...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};

    always @(posedge clock) begin
        cyc   = cyc + 1;
        rst_q = reset;
    end

    function automatic int idx_of(input string p);
        for (int i = 0; i < 8; i++)
            if (pats[i] == p) return i;
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic sched(input int c, input string p);
        ev_t e;
        int  id;
        id    = idx_of(p);
        e.cyc = c;
        e.err = (id < 0);
        e.idx = (id < 0) ? 0 : id;
        evq.push_back(e);
    endtask

    // Drive one level segment of n cycles; the model hears about it here.
    // A letter ends when a space of TH or more follows a mark; the pulse
    // lands TH+3 cycles after the key_in fall (2 sync + TH+1).
    task automatic put(input logic lvl, input int n);
        string s;
        @(negedge clock);
        bus.key_in = lvl;
        last_drive = cyc;
        last_n     = n;
        if (lvl) begin
            mlen = n;
        end else if (mlen > 0) begin
            s    = (mlen >= TH) ? "-" : ".";
            cur  = {cur, s};
            mlen = 0;
            if (n >= TH) begin
                sched(last_drive + TH + 3, cur);
                cur = "";
            end
        end
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clock);
    endtask

    task automatic hold();
        wait_to(last_drive + last_n - 1);
    endtask

    // Send a pattern with dot=1 unit, dash=3 units; leaves the tail low started
    task automatic send(input string pat, input int gap, input int tail);
        byte c;
        for (int i = 0; i < pat.len(); i++) begin
            c = pat[i];
            put(1'b1, (c == "-") ? 3 * UNIT : UNIT);
            hold();
            if (i != pat.len() - 1) begin
                put(1'b0, gap);
                hold();
            end
        end
        put(1'b0, tail);
    endtask

    // Per-cycle compare of pulses and letter against the model
    initial begin
        int   exp_letter;
        bit   elv, eer;
        ev_t  e;
        exp_letter = 0;
        forever begin
            @(negedge clock);
            elv = 1'b0;
            eer = 1'b0;
            if (rst_q) begin
                evq.delete();
                exp_letter = 0;
                chk("rst_state", {bus.busy, bus.sym_len, bus.sym_bits}, 32'd0);
            end else if (evq.size() > 0 && evq[0].cyc == cyc) begin
                e = evq.pop_front();
                elv = !e.err;
                eer = e.err;
                if (!e.err) exp_letter = e.idx;
            end
            chk("pulse", {bus.letter_valid, bus.error, bus.letter},
                {elv, eer, 3'(exp_letter)});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish, %0d cycles", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int d;
        bus.key_in = 1'b0;

        // Reset with the line toggling
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            bus.key_in = ~bus.key_in;
            chk("reset_out", {bus.letter_valid, bus.error, bus.letter, bus.busy}, 32'd0);
        end
        @(negedge clock);
        bus.key_in = 1'b0;
        reset = 1'b0;
        repeat (4) @(negedge clock);

        // V: symbols visible just before EMIT, pulse TH+1 after synced fall
        send("...-", UNIT, 4 * UNIT);
        d = last_drive;
        wait_to(d + TH + 1);
        chk("v_sym_len", bus.sym_len, 32'd4);
        chk("v_sym_bits", bus.sym_bits, 32'b0001);
        wait_to(d + TH + 3);
        chk("v_letter", {bus.letter_valid, bus.error, bus.letter}, {2'b10, 3'd3});
        hold();

        // T with latency pin
        send("-", UNIT, 4 * UNIT);
        d = last_drive;
        wait_to(d + TH + 2);
        chk("t_early", bus.letter_valid, 32'd0);
        wait_to(d + TH + 3);
        chk("t_letter", {bus.letter_valid, bus.letter}, {1'b1, 3'd1});
        hold();

        // Z
        send("--..", UNIT, 4 * UNIT);
        d = last_drive;
        wait_to(d + TH + 3);
        chk("z_letter", {bus.letter_valid, bus.letter}, {1'b1, 3'd7});
        hold();

        // E is unsupported: error, letter keeps Z
        send(".", UNIT, 4 * UNIT);
        d = last_drive;
        wait_to(d + TH + 3);
        chk("e_error", {bus.letter_valid, bus.error, bus.letter}, {2'b01, 3'd7});
        hold();

        // Five dots overflow
        send(".....", UNIT, 4 * UNIT);
        d = last_drive;
        wait_to(d + TH + 1);
        chk("ovf_len", bus.sym_len, 32'd5);
        wait_to(d + TH + 3);
        chk("ovf_error", {bus.letter_valid, bus.error}, 32'b01);
        hold();

        // Mark boundary: 7 cycles is a dot (E -> error), 8 is a dash (T)
        put(1'b1, TH - 1); hold(); put(1'b0, 16);
        d = last_drive;
        wait_to(d + TH + 3);
        chk("mark7_dot", {bus.letter_valid, bus.error}, 32'b01);
        hold();
        put(1'b1, TH); hold(); put(1'b0, 16);
        d = last_drive;
        wait_to(d + TH + 3);
        chk("mark8_dash", {bus.letter_valid, bus.letter}, {1'b1, 3'd1});
        hold();

        // Space boundary: 7-cycle gaps keep "..." as S
        send("...", TH - 1, 16);
        d = last_drive;
        wait_to(d + TH + 3);
        chk("space7_open", {bus.letter_valid, bus.letter}, {1'b1, 3'd0});
        hold();

        // 8-cycle gap closes the letter; next mark rises during EMIT
        put(1'b1, UNIT); hold(); put(1'b0, TH);
        d = last_drive;
        hold();
        put(1'b1, UNIT);
        wait_to(d + TH + 3);
        chk("space8_emit", {bus.letter_valid, bus.error}, 32'b01);
        hold();
        put(1'b0, 16); hold();

        // Reset in the middle of a mark discards the letter
        put(1'b1, 20);
        wait_to(last_drive + 6);
        chk("midmark_busy", bus.busy, 32'd1);
        @(negedge clock);
        reset = 1'b1;
        bus.key_in = 1'b0;
        cur  = "";
        mlen = 0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (30) @(negedge clock);
        chk("midmark_idle", bus.busy, 32'd0);

        // Loopback of encoder streams for every switch code
        for (int code = 0; code < 8; code++) begin
            send(pats[code], UNIT, 3 * UNIT);
            d = last_drive;
            wait_to(d + TH + 3);
            chk("loopback", {bus.letter_valid, bus.error, bus.letter}, {2'b10, 3'(code)});
            hold();
        end

        // Random marks and spaces against the model
        repeat (40) begin
            put(1'b1, $urandom_range(1, 14));
            hold();
            put(1'b0, ($urandom_range(0, 3) == 0) ? $urandom_range(TH, 20)
                                                   : $urandom_range(1, TH + 1));
            hold();
        end
        put(1'b1, UNIT); hold();
        put(1'b0, 20); hold();
        chk("drained", evq.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
